// File: rtl/gmf_pkg.sv
// Shared types and helpers for group_max_forwarder: bank states and the
// mode-to-group-length mapping.
package gmf_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_FULL  = 2'd2
  } bank_state_t;

  localparam int unsigned BYPASS_MODE_MAX = 2;

  // Modes up to BYPASS_MODE_MAX pass rows through singly; larger modes group m-1 rows.
  function automatic int unsigned rows_for_mode(input int unsigned mode, input int unsigned max_rows);
    int unsigned rows;
    rows = (mode <= BYPASS_MODE_MAX) ? 1 : mode - 1;
    return (rows > max_rows) ? max_rows : rows;
  endfunction

endpackage

// File: rtl/gmf_bank.sv
// One storage bank of group_max_forwarder: row payload store, fill/drain state,
// row counter, running signed max and the group's latched mode.
module gmf_bank
  import gmf_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PAYLOAD_W = 1024,
  parameter int MAX_ROWS  = 12,
  parameter int MODE_W    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr,
  input  logic                     i_flush,
  input  logic signed [DATA_W-1:0] i_loc_max,
  input  logic [MODE_W-1:0]        i_length_mode,
  input  logic [PAYLOAD_W-1:0]     i_payload,
  input  logic                     i_rd,
  output bank_state_t              o_state,
  output logic                     o_closing,
  output logic signed [DATA_W-1:0] o_rd_max,
  output logic [MODE_W-1:0]        o_rd_mode,
  output logic [PAYLOAD_W-1:0]     o_rd_payload,
  output logic                     o_rd_last
);

  localparam int CNT_W = $clog2(MAX_ROWS + 1);

  bank_state_t               r_state, w_state_next;
  logic [CNT_W-1:0]          r_cnt, w_cnt_next;
  logic [CNT_W-1:0]          r_len, w_len_next;
  logic [CNT_W-1:0]          r_rd_idx, w_rd_idx_next;
  logic signed [DATA_W-1:0]  r_max, w_max_next;
  logic [MODE_W-1:0]         r_mode, w_mode_next;
  logic [CNT_W-1:0]          w_len_first;
  logic [CNT_W-1:0]          w_wr_idx;
  logic [PAYLOAD_W-1:0]      r_mem [MAX_ROWS];

  assign w_len_first = CNT_W'(rows_for_mode(32'(i_length_mode), MAX_ROWS));
  assign w_wr_idx    = (r_state == BANK_EMPTY) ? '0 : r_cnt;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_len_next    = r_len;
    w_rd_idx_next = r_rd_idx;
    w_max_next    = r_max;
    w_mode_next   = r_mode;
    case (r_state)
      BANK_EMPTY: begin
        if (i_wr) begin
          w_mode_next   = i_length_mode;
          w_len_next    = w_len_first;
          w_cnt_next    = CNT_W'(1);
          w_max_next    = i_loc_max;
          w_rd_idx_next = '0;
          w_state_next  = (w_len_first == CNT_W'(1)) ? BANK_FULL : BANK_FILL;
        end
      end
      BANK_FILL: begin
        if (i_wr) begin
          w_cnt_next = r_cnt + 1'b1;
          if (i_loc_max > r_max) w_max_next = i_loc_max;
        end
        // A flush seals the group at whatever count it reaches this edge.
        if (i_wr && (r_cnt + 1'b1 == r_len)) begin
          w_state_next = BANK_FULL;
        end else if (i_flush) begin
          w_state_next = BANK_FULL;
          w_len_next   = w_cnt_next;
        end
      end
      BANK_FULL: begin
        if (i_rd) begin
          if (o_rd_last) begin
            w_state_next  = BANK_EMPTY;
            w_rd_idx_next = '0;
          end else begin
            w_rd_idx_next = r_rd_idx + 1'b1;
          end
        end
      end
      default: w_state_next = BANK_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= BANK_EMPTY;
      r_cnt    <= '0;
      r_len    <= '0;
      r_rd_idx <= '0;
      r_max    <= '0;
      r_mode   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_len    <= w_len_next;
      r_rd_idx <= w_rd_idx_next;
      r_max    <= w_max_next;
      r_mode   <= w_mode_next;
    end
  end

  // Payload store carries no reset so it maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr) r_mem[w_wr_idx] <= i_payload;
  end

  assign o_state      = r_state;
  assign o_closing    = (r_state != BANK_FULL) && (w_state_next == BANK_FULL);
  assign o_rd_max     = r_max;
  assign o_rd_mode    = r_mode;
  assign o_rd_payload = r_mem[r_rd_idx];
  assign o_rd_last    = (r_rd_idx == r_len - 1'b1);

endmodule

// File: rtl/group_max_forwarder.sv
// Two-bank group max forwarder: groups fill one bank while the other drains,
// every row leaves tagged with its group's signed max. GMF_FLUSH_EN adds i_flush.
module group_max_forwarder
  import gmf_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PAYLOAD_W = 1024,
  parameter int MAX_ROWS  = 12,
  parameter int MODE_W    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [DATA_W-1:0] i_loc_max,
  input  logic [MODE_W-1:0]        i_length_mode,
  input  logic [PAYLOAD_W-1:0]     i_in_flat,
`ifdef GMF_FLUSH_EN
  input  logic                     i_flush,
`endif
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DATA_W-1:0] o_global_max,
  output logic [MODE_W-1:0]        o_length_mode_byp,
  output logic [PAYLOAD_W-1:0]     o_in_byp,
  output logic                     o_last
);

  logic                     r_wr_ptr, r_rd_ptr;
  logic                     w_accept, w_xfer, w_flush;
  bank_state_t              w_state      [2];
  logic                     w_closing    [2];
  logic                     w_rd_last    [2];
  logic signed [DATA_W-1:0] w_rd_max     [2];
  logic [MODE_W-1:0]        w_rd_mode    [2];
  logic [PAYLOAD_W-1:0]     w_rd_payload [2];

`ifdef GMF_FLUSH_EN
  assign w_flush = i_flush & i_en;
`else
  assign w_flush = 1'b0;
`endif

  assign o_ready  = (w_state[r_wr_ptr] != BANK_FULL) & ~i_rst;
  assign o_valid  = (w_state[r_rd_ptr] == BANK_FULL);
  assign w_accept = i_valid & o_ready & i_en;
  assign w_xfer   = o_valid & i_ready & i_en;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      gmf_bank #(
        .DATA_W   (DATA_W),
        .PAYLOAD_W(PAYLOAD_W),
        .MAX_ROWS (MAX_ROWS),
        .MODE_W   (MODE_W)
      ) u_bank (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wr         (w_accept & (r_wr_ptr == 1'(gi))),
        .i_flush      (w_flush & (r_wr_ptr == 1'(gi))),
        .i_loc_max    (i_loc_max),
        .i_length_mode(i_length_mode),
        .i_payload    (i_in_flat),
        .i_rd         (w_xfer & (r_rd_ptr == 1'(gi))),
        .o_state      (w_state[gi]),
        .o_closing    (w_closing[gi]),
        .o_rd_max     (w_rd_max[gi]),
        .o_rd_mode    (w_rd_mode[gi]),
        .o_rd_payload (w_rd_payload[gi]),
        .o_rd_last    (w_rd_last[gi])
      );
    end
  endgenerate

  // Outputs are forced to zero when idle so they match their reset values.
  assign o_global_max      = o_valid ? w_rd_max[r_rd_ptr]     : '0;
  assign o_length_mode_byp = o_valid ? w_rd_mode[r_rd_ptr]    : '0;
  assign o_in_byp          = o_valid ? w_rd_payload[r_rd_ptr] : '0;
  assign o_last            = o_valid & w_rd_last[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_closing[r_wr_ptr]) r_wr_ptr <= ~r_wr_ptr;
      if (w_xfer && w_rd_last[r_rd_ptr]) r_rd_ptr <= ~r_rd_ptr;
    end
  end

endmodule

// File: tb/tb_group_max_forwarder.sv
// Randomized self-checking bench for group_max_forwarder against a queue-based
// group model; covers GMF_FLUSH_EN when defined.
module tb_group_max_forwarder;

  typedef struct {
    logic signed [15:0] lm;
    logic [3:0]         mode;
    logic [1023:0]      pay;
  } row_t;

  typedef struct {
    logic signed [15:0] mx;
    logic [3:0]         mode;
    logic [1023:0]      pay;
    logic               last;
  } exp_t;

  logic               i_clk = 1'b0;
  logic               i_rst, i_en, i_valid, i_ready;
  logic signed [15:0] i_loc_max;
  logic [3:0]         i_length_mode;
  logic [1023:0]      i_in_flat;
  logic               o_ready, o_valid, o_last;
  logic signed [15:0] o_global_max;
  logic [3:0]         o_length_mode_byp;
  logic [1023:0]      o_in_byp;
`ifdef GMF_FLUSH_EN
  logic               i_flush;
`endif

  group_max_forwarder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid), .o_ready(o_ready),
    .i_loc_max(i_loc_max), .i_length_mode(i_length_mode), .i_in_flat(i_in_flat),
`ifdef GMF_FLUSH_EN
    .i_flush(i_flush),
`endif
    .o_valid(o_valid), .i_ready(i_ready), .o_global_max(o_global_max),
    .o_length_mode_byp(o_length_mode_byp), .o_in_byp(o_in_byp), .o_last(o_last)
  );

  always #5 i_clk = ~i_clk;

  int   n_vec = 0, n_err = 0;
  row_t src_q[$];
  row_t open_rows[$];
  exp_t exp_q[$];
  bit   open_active = 0;
  int   open_len, closed_cnt = 0;
  logic [3:0] open_mode;
  int   vld_pct = 100, rdy_pct = 100, en_pct = 100, fl_pct = 0;
  bit   watch_ready = 0;
  int   ready_drops = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rfm(input int m);
    int r;
    r = (m <= 2) ? 1 : m - 1;
    return (r > 12) ? 12 : r;
  endfunction

  function automatic logic [1023:0] rand_pay();
    logic [1023:0] p;
    for (int k = 0; k < 32; k++) p[k*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic logic [63:0] fold(input logic [1023:0] p);
    logic [63:0] f = '0;
    for (int k = 0; k < 16; k++) f ^= p[k*64 +: 64];
    return f;
  endfunction

  task automatic push_row(input int mode, input int lm);
    row_t r;
    r.lm = 16'(lm); r.mode = 4'(mode); r.pay = rand_pay();
    src_q.push_back(r);
  endtask

  task automatic close_group();
    logic signed [15:0] mx;
    exp_t e;
    mx = open_rows[0].lm;
    foreach (open_rows[k]) if (open_rows[k].lm > mx) mx = open_rows[k].lm;
    foreach (open_rows[k]) begin
      e.mx = mx; e.mode = open_mode; e.pay = open_rows[k].pay;
      e.last = (k == open_rows.size() - 1);
      exp_q.push_back(e);
    end
    open_rows.delete();
    open_active = 0;
    closed_cnt++;
  endtask

  task automatic drive();
    if (src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
      i_valid = 1'b1; i_loc_max = src_q[0].lm;
      i_length_mode = src_q[0].mode; i_in_flat = src_q[0].pay;
    end else begin
      i_valid = 1'b0; i_loc_max = 16'($urandom);
      i_length_mode = 4'($urandom); i_in_flat = rand_pay();
    end
    i_ready = ($urandom_range(99) < rdy_pct);
    i_en    = ($urandom_range(99) < en_pct);
`ifdef GMF_FLUSH_EN
    i_flush = ($urandom_range(99) < fl_pct);
`endif
  endtask

  task automatic step();
    bit exp_ready, exp_valid, acc, xfer, fl;
    row_t r;
    exp_t e;
    @(negedge i_clk);
    exp_ready = (closed_cnt < 2);
    exp_valid = (closed_cnt > 0);
    if (watch_ready && !o_ready) ready_drops++;
    check_val("o_ready", 64'(o_ready), 64'(exp_ready));
    check_val("o_valid", 64'(o_valid), 64'(exp_valid));
    if (exp_valid) begin
      e = exp_q[0];
      check_val("o_global_max", 64'(o_global_max), 64'(e.mx));
      check_val("o_length_mode_byp", 64'(o_length_mode_byp), 64'(e.mode));
      check_val("o_in_byp", fold(o_in_byp), fold(e.pay));
      check_val("o_last", 64'(o_last), 64'(e.last));
    end
    acc  = i_valid & exp_ready & i_en;
    xfer = exp_valid & i_ready & i_en;
`ifdef GMF_FLUSH_EN
    fl = i_flush & i_en & open_active;
`else
    fl = 1'b0;
`endif
    @(posedge i_clk);
    if (xfer) begin
      e = exp_q.pop_front();
      if (e.last) closed_cnt--;
    end
    if (acc) begin
      if (!open_active) begin
        open_active = 1; open_mode = i_length_mode; open_len = rfm(int'(i_length_mode));
      end
      r.lm = i_loc_max; r.mode = i_length_mode; r.pay = i_in_flat;
      open_rows.push_back(r);
      void'(src_q.pop_front());
    end
    if (open_active && (open_rows.size() == open_len || fl)) close_group();
    #1;
    drive();
  endtask

  task automatic run_until_idle(input int max_cyc);
    int c = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || open_active) && c < max_cyc) begin
      step();
      c++;
    end
    check_val("idle_reached", 64'(src_q.size() + exp_q.size() + int'(open_active)), 64'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_o_valid"}, 64'(o_valid), 64'(0));
    check_val({tag, "_o_global_max"}, 64'(o_global_max), 64'(0));
    check_val({tag, "_o_mode_byp"}, 64'(o_length_mode_byp), 64'(0));
    check_val({tag, "_o_in_byp"}, fold(o_in_byp), 64'(0));
    check_val({tag, "_o_last"}, 64'(o_last), 64'(0));
  endtask

  task automatic reset_mid();
    #2 i_rst = 1'b1;
    #1;
    check_val("rst_o_ready_held", 64'(o_ready), 64'(0));
    check_idle_outputs("rst_held");
    src_q.delete(); open_rows.delete(); exp_q.delete();
    open_active = 0; closed_cnt = 0;
    i_valid = 1'b0;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    #1;
    check_val("rst_o_ready_rel", 64'(o_ready), 64'(1));
    check_idle_outputs("rst_rel");
    drive();
  endtask

  initial begin
    int mode, n, c;
    i_rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_loc_max = '0; i_length_mode = '0; i_in_flat = '0;
`ifdef GMF_FLUSH_EN
    i_flush = 1'b0;
`endif
    #3;
    check_idle_outputs("por");
    check_val("por_o_ready", 64'(o_ready), 64'(0));
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    #1 check_val("por_o_ready_rel", 64'(o_ready), 64'(1));
    drive();

    // 1: single mode-3 group
    push_row(3, 100); push_row(3, 101);
    run_until_idle(50);

    // 2: back-to-back 3/13/4, input must never stall
    push_row(3, 100); push_row(3, 101);
    for (int k = 0; k < 12; k++) push_row(13, 200 + k);
    for (int k = 0; k < 3; k++) push_row(4, 300 + k);
    drive();
    watch_ready = 1; ready_drops = 0;
    while (src_q.size() > 0 && ready_drops < 100) step();
    watch_ready = 0;
    check_val("t2_ready_held", 64'(ready_drops), 64'(0));
    run_until_idle(100);

    // 3: bypass modes
    push_row(0, 999); push_row(1, 888); push_row(2, -5);
    drive();
    run_until_idle(50);

    // 4: signed max in the middle row, mode changes mid-group are ignored
    for (int k = 0; k < 6; k++) push_row((k == 0) ? 13 : k, -100 + k);
    push_row(3, -3);
    for (int k = 0; k < 5; k++) push_row(13, -94 + k);
    drive();
    run_until_idle(100);

    // 5: stalled sink while two more groups arrive
    rdy_pct = 0;
    for (int k = 0; k < 12; k++) push_row(13, k * 7 - 40);
    push_row(3, 5); push_row(3, 6);
    for (int k = 0; k < 3; k++) push_row(4, -k);
    drive();
    for (int k = 0; k < 30; k++) step();
    check_val("t5_ready_low", 64'(o_ready), 64'(0));
    rdy_pct = 100;
    run_until_idle(200);

    // 6: reset during a mode-8 fill, then a clean mode-3 group
    for (int k = 0; k < 7; k++) push_row(8, 1000 + k);
    drive();
    repeat (3) step();
    reset_mid();
    push_row(3, 10); push_row(3, 20);
    drive();
    run_until_idle(50);

`ifdef GMF_FLUSH_EN
    // early close after 4 of 7 rows
    push_row(8, 5); push_row(8, 50); push_row(8, -7); push_row(8, 49);
    drive();
    c = 0;
    while (src_q.size() > 0 && c < 50) begin step(); c++; end
    i_flush = 1'b1;
    step();
    check_val("flush_rows_out", 64'(exp_q.size()), 64'(4));
    run_until_idle(50);
`endif

    // randomized mix with enable, valid and ready gaps
    vld_pct = 80; rdy_pct = 70; en_pct = 90;
`ifdef GMF_FLUSH_EN
    fl_pct = 3;
`endif
    for (int g = 0; g < 60; g++) begin
      mode = $urandom_range(15);
      n = rfm(mode);
      for (int k = 0; k < n; k++)
        push_row((k == 0) ? mode : int'($urandom_range(15)), int'($urandom_range(65535)) - 32768);
    end
    drive();
    run_until_idle(20000);
    fl_pct = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
